// File: rtl/irq_request_latch_pkg.sv
// irq_pkg: shared types and constants for the interrupt request latch.
//   NCHAN    - channels per bank (fixed at 9 for the 432 controller)
//   CHAN_MAX - highest valid controller channel index
//   bank_t   - bank encoding BANK_A/BANK_B/BANK_C
//   state_t  - offer FSM states IDLE/SETTLE/OFFER
package irq_pkg;

    localparam int unsigned NCHAN = 9;

    typedef logic [NCHAN-1:0] chan_vec_t;
    typedef logic [3:0]       chan_t;
    typedef logic [1:0]       bank_t;

    localparam bank_t BANK_A = 2'd0;
    localparam bank_t BANK_B = 2'd1;
    localparam bank_t BANK_C = 2'd2;

    localparam chan_t CHAN_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OFFER
    } state_t;

endpackage

// File: rtl/irq_request_latch_if.sv
// irq_request_latch_if: CPU-facing offer handshake.
//   irq_valid - offer present            (master -> slave)
//   irq_bank  - bank of the offer        (master -> slave)
//   irq_chan  - channel of the offer     (master -> slave)
//   irq_err   - invalid-channel pulse    (master -> slave)
//   irq_ready - CPU accepts the offer    (slave -> master)
interface irq_request_latch_if;

    logic          irq_valid;
    logic          irq_ready;
    irq_pkg::bank_t irq_bank;
    irq_pkg::chan_t irq_chan;
    logic          irq_err;

    modport master (
        output irq_valid,
        output irq_bank,
        output irq_chan,
        output irq_err,
        input  irq_ready
    );

    modport slave (
        input  irq_valid,
        input  irq_bank,
        input  irq_chan,
        input  irq_err,
        output irq_ready
    );

endinterface

// File: rtl/irq_request_latch_edge_sync.sv
// irq_edge_sync: optional 2-flop synchroniser followed by a rising-edge detector.
// Build option: IRQ_SYNC_EN adds the synchroniser (2 cycles of extra latency);
// without it the request lines are assumed synchronous to clk.
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   req   - raw request lines
//   rise  - one-cycle pulse per rising edge of the (synchronised) request
module irq_edge_sync #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] req,
    output logic [Width-1:0] rise
);

    logic [Width-1:0] req_s;
    logic [Width-1:0] prev_q;

`ifdef IRQ_SYNC_EN
    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= req_s;
        end
    end

    assign rise = req_s & ~prev_q;

endmodule

// File: rtl/irq_request_latch.sv
// irq_request_latch: capture stage in front of the 27-channel priority controller.
// Build option: IRQ_SYNC_EN enables 2-flop request synchronisers in irq_edge_sync.
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_a/req_b/req_c      - raw request lines, rising edge raises a request
//   en                     - per-channel enable, shared by all banks
//   e_out                  - registered en, controller E input
//   pend_a/pend_b/pend_c   - pending bits, controller A/B/C inputs
//   pa/pb/pc, chan         - controller result (combinational from pend/e_out)
//   bus                    - CPU offer handshake (master side)
module irq_request_latch
    import irq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  chan_vec_t           req_a,
    input  chan_vec_t           req_b,
    input  chan_vec_t           req_c,
    input  chan_vec_t           en,
    output chan_vec_t           e_out,
    output chan_vec_t           pend_a,
    output chan_vec_t           pend_b,
    output chan_vec_t           pend_c,
    input  logic                pa,
    input  logic                pb,
    input  logic                pc,
    input  chan_t               chan,
    irq_request_latch_if.master bus
);

    chan_vec_t rise_a, rise_b, rise_c;
    chan_vec_t clr_a, clr_b, clr_c;
    chan_vec_t e_q, pend_a_q, pend_b_q, pend_c_q;
    state_t    state_q;
    logic      valid_q, err_q;
    bank_t     bank_q;
    chan_t     chan_q;
    logic      any_pend;
    logic      accept;

    irq_edge_sync #(.Width(NCHAN)) u_sync_a (.clk(clk), .rst_n(rst_n), .req(req_a), .rise(rise_a));
    irq_edge_sync #(.Width(NCHAN)) u_sync_b (.clk(clk), .rst_n(rst_n), .req(req_b), .rise(rise_b));
    irq_edge_sync #(.Width(NCHAN)) u_sync_c (.clk(clk), .rst_n(rst_n), .req(req_c), .rise(rise_c));

    assign accept   = (state_q == OFFER) && bus.irq_ready;
    assign any_pend = |((pend_a_q | pend_b_q | pend_c_q) & e_q);

    // chan_q is always <= CHAN_MAX while in OFFER, so the shift stays in range.
    always_comb begin
        clr_a = '0;
        clr_b = '0;
        clr_c = '0;
        if (accept) begin
            case (bank_q)
                BANK_A:  clr_a = chan_vec_t'(1) << chan_q;
                BANK_B:  clr_b = chan_vec_t'(1) << chan_q;
                default: clr_c = chan_vec_t'(1) << chan_q;
            endcase
        end
    end

    // Set is OR-ed in after the clear so a same-cycle new edge is retained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q      <= '0;
            pend_a_q <= '0;
            pend_b_q <= '0;
            pend_c_q <= '0;
        end else begin
            e_q      <= en;
            pend_a_q <= (pend_a_q & ~clr_a) | (rise_a & en);
            pend_b_q <= (pend_b_q & ~clr_b) | (rise_b & en);
            pend_c_q <= (pend_c_q & ~clr_c) | (rise_c & en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            bank_q  <= BANK_A;
            chan_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_pend) state_q <= SETTLE;
                end
                SETTLE: begin
                    if (!(pa | pb | pc)) begin
                        state_q <= IDLE;
                    end else if (chan > CHAN_MAX) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        bank_q  <= pa ? BANK_A : (pb ? BANK_B : BANK_C);
                        chan_q  <= chan;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.irq_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign e_out         = e_q;
    assign pend_a        = pend_a_q;
    assign pend_b        = pend_b_q;
    assign pend_c        = pend_c_q;
    assign bus.irq_valid = valid_q;
    assign bus.irq_bank  = bank_q;
    assign bus.irq_chan  = chan_q;
    assign bus.irq_err   = err_q;

endmodule

// File: tb/tb_irq_request_latch.sv
module tb_irq_request_latch;
    import irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct packed {
        logic [1:0] bank;
        logic [3:0] chan;
    } offer_t;

    logic      clk;
    logic      rst_n;
    chan_vec_t req_a, req_b, req_c, en;
    chan_vec_t e_out, pend_a, pend_b, pend_c;
    logic      pa, pb, pc;
    chan_t     chan;
    logic      force_bad;
    chan_vec_t ma, mb, mc, w;

    int     n_tests;
    int     n_fail;
    offer_t sb_q[$];

    irq_request_latch_if bus ();

    irq_request_latch dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_a  (req_a),
        .req_b  (req_b),
        .req_c  (req_c),
        .en     (en),
        .e_out  (e_out),
        .pend_a (pend_a),
        .pend_b (pend_b),
        .pend_c (pend_c),
        .pa     (pa),
        .pb     (pb),
        .pc     (pc),
        .chan   (chan),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 432 controller: bank flags plus lowest active channel of the top bank.
    always_comb begin
        ma   = pend_a & e_out;
        mb   = pend_b & e_out;
        mc   = pend_c & e_out;
        pa   = |ma;
        pb   = |mb;
        pc   = |mc;
        w    = pa ? ma : (pb ? mb : mc);
        chan = 4'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (w[i]) chan = 4'(i);
        end
        if (force_bad) begin
            pa   = 1'b1;
            chan = 4'hB;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_offer(input string name);
        int     k;
        offer_t exp_o;
        k = 0;
        while (bus.irq_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (bus.irq_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: irq_valid=%b required 1", name, bus.irq_valid);
        end else if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected offer: bank=%0d chan=%0d required none",
                     name, bus.irq_bank, bus.irq_chan);
        end else begin
            exp_o = sb_q.pop_front();
            if ({bus.irq_bank, bus.irq_chan} !== exp_o) begin
                n_fail++;
                $display("FAIL %s offer: bank=%0d chan=%0d required bank=%0d chan=%0d",
                         name, bus.irq_bank, bus.irq_chan, exp_o.bank, exp_o.chan);
            end
        end
    endtask

    task automatic accept(input string name);
        bus.irq_ready = 1'b1;
        tick();
        bus.irq_ready = 1'b0;
        n_tests++;
        if (bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid after accept: got %b required 0", name, bus.irq_valid);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({bus.irq_valid, bus.irq_err, bus.irq_bank, bus.irq_chan} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_offer: got v=%b e=%b b=%0d c=%0d required all 0",
                     bus.irq_valid, bus.irq_err, bus.irq_bank, bus.irq_chan);
        end
        n_tests++;
        if ({pend_a, pend_b, pend_c, e_out} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %h required 0", pend_a, pend_b, pend_c, e_out);
        end
        rst_n = 1'b1;
        ticks(2);
        n_tests++;
        if (bus.irq_valid !== 1'b0 || e_out !== 9'h1FF) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b e_out=%h required 0 1ff", bus.irq_valid, e_out);
        end
    endtask

    task automatic test_single();
        req_b[3] = 1'b1;
        sb_q.push_back('{bank: BANK_B, chan: 4'd3});
        ticks(1 + SYNC_LAT);
        n_tests++;
        if (pend_b !== 9'h008) begin
            n_fail++;
            $display("FAIL single_pend: got %h required 008", pend_b);
        end
        tick();
        n_tests++;
        if (bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_settle: valid=%b required 0", bus.irq_valid);
        end
        tick();
        n_tests++;
        if (bus.irq_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: valid=%b required 1", bus.irq_valid);
        end
        expect_offer("single_offer");
        accept("single");
        n_tests++;
        if (pend_b !== 9'h000) begin
            n_fail++;
            $display("FAIL single_clear: got %h required 000", pend_b);
        end
        tick();
        n_tests++;
        if (bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gap: valid=%b required 0", bus.irq_valid);
        end
        req_b[3] = 1'b0;
        ticks(3);
    endtask

    task automatic test_priority();
        req_a[5] = 1'b1;
        req_c[0] = 1'b1;
        sb_q.push_back('{bank: BANK_A, chan: 4'd5});
        sb_q.push_back('{bank: BANK_C, chan: 4'd0});
        expect_offer("prio_first");
        accept("prio_first");
        expect_offer("prio_second");
        accept("prio_second");
        n_tests++;
        if (pend_a !== 9'h000 || pend_c !== 9'h000) begin
            n_fail++;
            $display("FAIL prio_clear: a=%h c=%h required 000 000", pend_a, pend_c);
        end
        req_a[5] = 1'b0;
        req_c[0] = 1'b0;
        ticks(3);
    endtask

    task automatic test_collision();
        req_a[5] = 1'b1;
        sb_q.push_back('{bank: BANK_A, chan: 4'd5});
        expect_offer("coll_first");
        req_a[5] = 1'b0;
        ticks(1 + SYNC_LAT);
        req_a[5] = 1'b1;
        ticks(SYNC_LAT);
        n_tests++;
        if ({bus.irq_valid, bus.irq_bank, bus.irq_chan} !== {1'b1, BANK_A, 4'd5}) begin
            n_fail++;
            $display("FAIL coll_hold: v=%b b=%0d c=%0d required 1 0 5",
                     bus.irq_valid, bus.irq_bank, bus.irq_chan);
        end
        accept("coll_first");
        n_tests++;
        if (pend_a !== 9'h020) begin
            n_fail++;
            $display("FAIL coll_retain: got %h required 020", pend_a);
        end
        sb_q.push_back('{bank: BANK_A, chan: 4'd5});
        expect_offer("coll_second");
        accept("coll_second");
        n_tests++;
        if (pend_a !== 9'h000) begin
            n_fail++;
            $display("FAIL coll_clear: got %h required 000", pend_a);
        end
        req_a[5] = 1'b0;
        ticks(3);
    endtask

    task automatic test_disabled();
        int seen;
        seen = 0;
        en = 9'h1FB;
        req_c[2] = 1'b1;
        for (int i = 0; i < 6 + SYNC_LAT; i++) begin
            tick();
            if (bus.irq_valid === 1'b1) seen++;
        end
        n_tests++;
        if (pend_c !== 9'h000 || seen != 0 || e_out !== 9'h1FB) begin
            n_fail++;
            $display("FAIL dis_drop: pend_c=%h offers=%0d e_out=%h required 000 0 1fb",
                     pend_c, seen, e_out);
        end
        en = 9'h1FF;
        for (int i = 0; i < 6 + SYNC_LAT; i++) begin
            tick();
            if (bus.irq_valid === 1'b1) seen++;
        end
        n_tests++;
        if (pend_c !== 9'h000 || seen != 0) begin
            n_fail++;
            $display("FAIL dis_resurrect: pend_c=%h offers=%0d required 000 0", pend_c, seen);
        end
        req_c[2] = 1'b0;
        ticks(3);
    endtask

    task automatic test_invalid();
        force_bad = 1'b1;
        req_a[1] = 1'b1;
        ticks(1 + SYNC_LAT);
        n_tests++;
        if (pend_a !== 9'h002) begin
            n_fail++;
            $display("FAIL inv_pend: got %h required 002", pend_a);
        end
        ticks(2);
        n_tests++;
        if (bus.irq_err !== 1'b1 || bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_err: err=%b valid=%b required 1 0", bus.irq_err, bus.irq_valid);
        end
        tick();
        n_tests++;
        if (bus.irq_err !== 1'b0 || pend_a !== 9'h002) begin
            n_fail++;
            $display("FAIL inv_pulse: err=%b pend_a=%h required 0 002", bus.irq_err, pend_a);
        end
        tick();
        n_tests++;
        if (bus.irq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_rearb: err=%b required 1", bus.irq_err);
        end
        force_bad = 1'b0;
        sb_q.push_back('{bank: BANK_A, chan: 4'd1});
        expect_offer("inv_recover");
        accept("inv_recover");
        n_tests++;
        if (pend_a !== 9'h000) begin
            n_fail++;
            $display("FAIL inv_clear: got %h required 000", pend_a);
        end
        req_a[1] = 1'b0;
        ticks(3);
    endtask

    task automatic test_reset_mid_offer();
        req_a[0] = 1'b1;
        sb_q.push_back('{bank: BANK_A, chan: 4'd0});
        expect_offer("rst_offer");
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.irq_valid !== 1'b0 || bus.irq_err !== 1'b0 ||
            {pend_a, pend_b, pend_c} !== 27'h0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b err=%b pend=%h %h %h required all 0",
                     bus.irq_valid, bus.irq_err, pend_a, pend_b, pend_c);
        end
        req_a[0] = 1'b0;
        #3;
        rst_n = 1'b1;
        ticks(4 + SYNC_LAT);
        n_tests++;
        if (bus.irq_valid !== 1'b0 || pend_a !== 9'h000 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_no_replay: valid=%b pend_a=%h queued=%0d required 0 000 0",
                     bus.irq_valid, pend_a, sb_q.size());
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        req_a         = '0;
        req_b         = '0;
        req_c         = '0;
        en            = 9'h1FF;
        force_bad     = 1'b0;
        bus.irq_ready = 1'b0;
        #12;
        test_reset();
        test_single();
        test_priority();
        test_collision();
        test_disabled();
        test_invalid();
        test_reset_mid_offer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
